// File: rtl/card_display_bank.sv
// card_display_bank: a bank of NUM_CH card-code registers. Each register
// drives one active-low 7-segment digit (gfedcba). A newly loaded valid card
// blinks BLINK_COUNT off/on pairs of BLINK_PERIOD cycles per half-phase,
// then its digit stays lit.
// Optional build macro SEG_SCAN_EN adds a time-multiplexed digit bus
// (scan_seg/scan_sel). Each digit is selected for SCAN_DIV cycles.
module card_display_bank #(
  parameter int NUM_CH       = 6,
  parameter int BLINK_PERIOD = 12500000,
  parameter int BLINK_COUNT  = 3,
  parameter int SCAN_DIV     = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [NUM_CH-1:0]     load,
  input  logic [4*NUM_CH-1:0]   card_in,
  output logic [7*NUM_CH-1:0]   seg7_out,
  output logic [NUM_CH-1:0]     busy
`ifdef SEG_SCAN_EN
  ,
  output logic [6:0]            scan_seg,
  output logic [NUM_CH-1:0]     scan_sel
`endif
);

  localparam int PH_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam int PR_W = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(BLINK_PERIOD - 1);
  localparam logic [PR_W-1:0] PR_LAST = PR_W'(BLINK_COUNT - 1);

  typedef enum logic [1:0] {IDLE, BLINK_OFF, BLINK_ON, STEADY} state_e;

  state_e          state_q [NUM_CH];
  logic [3:0]      code_q  [NUM_CH];
  logic [PH_W-1:0] phase_q [NUM_CH];
  logic [PR_W-1:0] pair_q  [NUM_CH];

  // Card code to active-low gfedcba pattern; codes outside 1..13 are blank.
  function automatic logic [6:0] dec7(input logic [3:0] c);
    case (c)
      4'd1:    dec7 = 7'b0001000;
      4'd2:    dec7 = 7'b0100100;
      4'd3:    dec7 = 7'b0110000;
      4'd4:    dec7 = 7'b0011001;
      4'd5:    dec7 = 7'b0010010;
      4'd6:    dec7 = 7'b0000010;
      4'd7:    dec7 = 7'b1111000;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0010000;
      4'd10:   dec7 = 7'b1000000;
      4'd11:   dec7 = 7'b1100001;
      4'd12:   dec7 = 7'b0011000;
      4'd13:   dec7 = 7'b0001001;
      default: dec7 = 7'b1111111;
    endcase
  endfunction

  // Per-channel load/blink state machine with its phase and pair counters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset || clear) begin
        state_q[i] <= IDLE;
        code_q[i]  <= 4'd0;
        phase_q[i] <= '0;
        pair_q[i]  <= '0;
      end else if (load[i]) begin
        code_q[i]  <= card_in[4*i +: 4];
        phase_q[i] <= '0;
        pair_q[i]  <= '0;
        if (card_in[4*i +: 4] != 4'd0 && card_in[4*i +: 4] <= 4'd13)
          state_q[i] <= (BLINK_COUNT > 0) ? BLINK_OFF : STEADY;
        else
          state_q[i] <= IDLE;
      end else begin
        case (state_q[i])
          BLINK_OFF: begin
            if (phase_q[i] == PH_LAST) begin
              phase_q[i] <= '0;
              state_q[i] <= BLINK_ON;
            end else begin
              phase_q[i] <= phase_q[i] + PH_W'(1);
            end
          end
          BLINK_ON: begin
            if (phase_q[i] == PH_LAST) begin
              phase_q[i] <= '0;
              if (pair_q[i] == PR_LAST) begin
                state_q[i] <= STEADY;
              end else begin
                pair_q[i]  <= pair_q[i] + PR_W'(1);
                state_q[i] <= BLINK_OFF;
              end
            end else begin
              phase_q[i] <= phase_q[i] + PH_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Digits show the card only in BLINK_ON/STEADY; busy marks the blink phases.
  always_comb begin
    seg7_out = '1;
    busy     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (state_q[i] == BLINK_ON || state_q[i] == STEADY)
        seg7_out[7*i +: 7] = dec7(code_q[i]);
      busy[i] = (state_q[i] == BLINK_OFF) || (state_q[i] == BLINK_ON);
    end
  end

`ifdef SEG_SCAN_EN
  localparam int SD_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [SD_W-1:0] SD_LAST = SD_W'(SCAN_DIV - 1);
  localparam logic [IX_W-1:0] IX_LAST = IX_W'(NUM_CH - 1);

  logic [SD_W-1:0] div_q;
  logic [IX_W-1:0] idx_q;

  // Scan divider and digit index; only reset touches them, never clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (div_q == SD_LAST) begin
      div_q <= '0;
      idx_q <= (idx_q == IX_LAST) ? '0 : idx_q + IX_W'(1);
    end else begin
      div_q <= div_q + SD_W'(1);
    end
  end

  // Route the selected channel's digit onto the shared bus.
  always_comb begin
    scan_seg = 7'b1111111;
    scan_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx_q == IX_W'(i)) begin
        scan_seg    = seg7_out[7*i +: 7];
        scan_sel[i] = 1'b1;
      end
    end
  end
`endif

endmodule
